// File: rtl/inst_mem_arbiter.sv
// Arbitrates the single-port combinational instruction ROM between CPU fetch and a debug reader,
// with 1-cycle registered responses and bounded fetch priority. Optional macro: ARB_ALIGN_CHK_EN.
module inst_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             misalign;

    // Fetch wins unless debug has already been passed over STARVE_MAX times in a row.
    assign if_gnt   = if_req & (~dbg_req | (starve_cnt < CNT_MAX));
    assign dbg_gnt  = dbg_req & ~if_gnt;
    assign if_stall = if_req & ~if_gnt;
    assign rom_addr = if_gnt ? if_addr : (dbg_gnt ? dbg_addr : '0);

`ifdef ARB_ALIGN_CHK_EN
    assign misalign = (rom_addr[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned grant still burns the slot but never touches the ROM.
    assign rom_ce = (if_gnt | dbg_gnt) & ~misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
            dbg_err    <= 1'b0;
        end else begin
            if (dbg_gnt || !dbg_req) begin
                starve_cnt <= '0;
            end else if (if_gnt && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            if_rvalid  <= if_gnt;
            dbg_rvalid <= dbg_gnt;
            if (if_gnt) begin
                if_rdata <= misalign ? '0 : rom_inst;
                if_err   <= misalign;
            end
            if (dbg_gnt) begin
                dbg_rdata <= misalign ? '0 : rom_inst;
                dbg_err   <= misalign;
            end
        end
    end
endmodule
